// File: rtl/c3lib_avmm_pulse_accum.sv
// Event accumulator that converts counted i_evt strobes into a pulse/ready handshake.
// Optional sticky overflow flag enabled by defining C3LIB_AVMM_PULSE_ACCUM_OVF_EN.
module c3lib_avmm_pulse_accum #(
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_evt,
    input  logic                 i_next_pulse,
    input  logic                 i_flush,
    input  logic                 i_ovf_clr,
    output logic                 o_pulse,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_busy,
    output logic                 o_ovf
);

    localparam logic [CNT_WIDTH-1:0] CntMax  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CntOne  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CntZero = {CNT_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StWait = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pulse_q;
    logic                 flushed_q, flushed_d;
    logic                 accept;
    logic                 dec;
    logic                 sat;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cnt_q != CntZero && i_next_pulse) state_d = StSend;
            StSend: if (!i_next_pulse) state_d = StWait;
            StWait: if (i_next_pulse) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A pulse whose event was flushed still completes its handshake but must not consume
    // any event that arrives after the flush.
    assign accept    = (state_q == StSend) && !i_next_pulse;
    assign dec       = accept && !flushed_q && (cnt_q != CntZero);
    assign sat       = i_evt && !i_flush && !dec && (cnt_q == CntMax);
    assign flushed_d = (state_d == StSend) && (i_flush || ((state_q == StSend) && flushed_q));

    always_comb begin
        cnt_d = cnt_q;
        if (i_flush) begin
            cnt_d = CntZero;
        end else if (i_evt && !dec && !sat) begin
            cnt_d = cnt_q + CntOne;
        end else if (dec && !i_evt) begin
            cnt_d = cnt_q - CntOne;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= StIdle;
            cnt_q     <= CntZero;
            pulse_q   <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulse_q   <= (state_d == StSend);
            flushed_q <= flushed_d;
        end
    end

`ifdef C3LIB_AVMM_PULSE_ACCUM_OVF_EN
    logic ovf_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ovf_q <= 1'b0;
        end else if (sat) begin
            ovf_q <= 1'b1;
        end else if (i_ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign o_ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = i_ovf_clr ^ sat;
    assign o_ovf      = 1'b0;
`endif

    assign o_pulse = pulse_q;
    assign o_cnt   = cnt_q;
    assign o_busy  = (cnt_q != CntZero) || (state_q != StIdle);

endmodule

// File: doc/c3lib_avmm_pulse_accum.md
C3LIB_AVMM_PULSE_ACCUM -- requirements
Module: c3lib_avmm_pulse_accum

Interface
REQ-001 Parameter CNT_WIDTH, default 4, SHALL set the width of the pending-event counter (legal range 2..8).
REQ-002 i_clk  input  1  SHALL be the single clock for all logic.
REQ-003 i_rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 i_evt  input  1  SHALL be the event strobe; each cycle it is high counts as one event.
REQ-005 i_next_pulse  input  1  SHALL be the ready indication from the downstream pulse-crossing stage (high = a new pulse will be accepted).
REQ-006 i_flush  input  1  SHALL be a synchronous clear of all pending events.
REQ-007 i_ovf_clr  input  1  SHALL be a synchronous clear of the sticky overflow flag.
REQ-008 o_pulse  output  1  SHALL be the pulse request driven to the downstream stage's i_pulse.
REQ-009 o_cnt  output  CNT_WIDTH  SHALL be the current pending-event count.
REQ-010 o_busy  output  1  SHALL be high when o_cnt != 0 or the FSM is not in IDLE.
REQ-011 o_ovf  output  1  SHALL be the sticky overflow flag.

Function
REQ-012 The FSM SHALL have states IDLE, SEND and WAIT, encoded in a registered state variable.
REQ-013 IDLE -> SEND SHALL occur when cnt != 0 and i_next_pulse == 1; otherwise the FSM SHALL stay in IDLE.
REQ-014 o_pulse SHALL be registered and high exactly while the FSM is in SEND.
REQ-015 SEND -> WAIT SHALL occur on the first cycle in which i_next_pulse == 0 (acceptance seen); the count SHALL decrement by 1 on that transition.
REQ-016 WAIT -> IDLE SHALL occur when i_next_pulse == 1; a back-to-back pulse can therefore leave IDLE on the following cycle.
REQ-017 Counter update per cycle SHALL be: +1 for i_evt only, -1 for acceptance only, and unchanged when both occur in the same cycle.
REQ-018 An increment at cnt == 2^CNT_WIDTH-1 without a simultaneous decrement SHALL saturate; the count SHALL NOT wrap.
REQ-019 The count SHALL never underflow; a decrement SHALL occur only from SEND, and SEND is entered only with cnt != 0.
REQ-020 i_flush SHALL force cnt to 0 and override same-cycle i_evt; the FSM SHALL NOT abort SEND, which completes its handshake with no decrement (the count remains 0).
REQ-021 Latency SHALL be: i_evt at cycle N with cnt = 0, the FSM in IDLE and i_next_pulse = 1 -> o_cnt = 1 at N+1, o_pulse high at N+2.
REQ-022 The FSM SHALL hold o_pulse high in SEND indefinitely until i_next_pulse falls; no timeout is applied.

Reset
REQ-023 On i_rstn low, the FSM SHALL go to IDLE and o_pulse, o_cnt, o_busy and o_ovf SHALL all be 0, asynchronously.
REQ-024 The first clock edge after reset deassertion SHALL evaluate normally; no event is lost beyond those arriving during reset.

Configuration
REQ-025 Macro C3LIB_AVMM_PULSE_ACCUM_OVF_EN: when defined, o_ovf SHALL set on any saturating increment attempt (REQ-018) and SHALL clear on i_ovf_clr, with set taking priority over clear in the same cycle.
REQ-026 When C3LIB_AVMM_PULSE_ACCUM_OVF_EN is undefined, o_ovf SHALL be tied to 0, i_ovf_clr SHALL be ignored, and no overflow register SHALL exist.

Verification
REQ-027 Scenario: i_next_pulse = 1 held, single i_evt -> o_cnt = 1, one o_pulse; the model drops i_next_pulse one cycle later -> o_cnt = 0, o_busy = 0.
REQ-028 Scenario: 5 consecutive i_evt while i_next_pulse = 0 -> o_cnt = 5, o_pulse = 0; release ready -> exactly 5 handshakes, final o_cnt = 0.
REQ-029 Scenario: CNT_WIDTH = 4, 17 i_evt with no acceptance -> o_cnt = 15; o_ovf = 1 with the macro defined and 0 without; i_ovf_clr -> o_ovf = 0.
REQ-030 Scenario: i_evt coincident with the SEND->WAIT acceptance at o_cnt = 3 -> o_cnt stays 3.
REQ-031 Scenario: i_flush while in SEND with o_cnt = 4 -> o_cnt = 0, o_pulse held until i_next_pulse = 0, no further pulses.
REQ-032 Scenario: i_rstn asserted mid-SEND with o_cnt = 6 -> all outputs 0 immediately; after release with i_next_pulse = 1, no o_pulse.
